proc_mem_responder: RTL and testbench

//  Word-addressed memory responder: far end of the processor's imem/dmem val/rdy ports.
//  - Accepts mem_req_4B_t requests (read/write/write-init).
//  - Performs the access after a programmable latency.
//  - Returns one mem_resp_4B_t per request, in order.
//  - Used as the on-chip data memory and as the memory model in processor tests.

---
 rtl/mem_msgs.sv | 26 ++
 rtl/proc_mem_responder_pkg.sv | 34 +++
 rtl/proc_mem_responder_if.sv | 23 ++
 rtl/proc_mem_responder_array.sv | 27 ++
 rtl/proc_mem_responder.sv | 126 ++++++++++++
 tb/tb_proc_mem_responder.sv | 379 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_msgs.sv
// Shared processor/memory message formats for the imem/dmem val/rdy streams.
// Request 78 bits, response 47 bits; field order matches the wire layout MSB first.
package mem_msgs;

  localparam logic [2:0] MEM_READ       = 3'd0;
  localparam logic [2:0] MEM_WRITE      = 3'd1;
  localparam logic [2:0] MEM_WRITE_INIT = 3'd2;

  // len uses two bits for 4/1/2/3 bytes; the spare top bit must be zero.
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/proc_mem_responder_pkg.sv
// Responder-local FSM encoding and byte-lane helpers.
// Pure definitions; no state.
package proc_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // len field 0 encodes a full 4-byte access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      3'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/proc_mem_responder_if.sv
// Request and response val/rdy streams between a requester (master) and the responder (slave).
// Both directions follow the val&&rdy transfer rule.
interface proc_mem_responder_if;
  import mem_msgs::*;

  logic         reqstream_val;
  logic         reqstream_rdy;
  mem_req_4B_t  reqstream_msg;
  logic         respstream_val;
  logic         respstream_rdy;
  mem_resp_4B_t respstream_msg;

  modport master (
    output reqstream_val, reqstream_msg, respstream_rdy,
    input  reqstream_rdy, respstream_val, respstream_msg
  );

  modport slave (
    input  reqstream_val, reqstream_msg, respstream_rdy,
    output reqstream_rdy, respstream_val, respstream_msg
  );

endinterface

// File: rtl/proc_mem_responder_array.sv
// 1r1w word array with per-byte write enables; combinational read, write on clk.
// Contents are not reset.
module proc_mem_responder_array #(
  parameter int unsigned p_num_words = 256
) (
  input  logic                           clk,
  input  logic [$clog2(p_num_words)-1:0] rd_idx,
  output logic [31:0]                    rd_data,
  input  logic                           wr_en,
  input  logic [$clog2(p_num_words)-1:0] wr_idx,
  input  logic [3:0]                     wr_be,
  input  logic [31:0]                    wr_data
);

  logic [31:0] mem_q [p_num_words];

  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Word-addressed memory responder: access on accept, response valid p_latency+1 cycles later.
// One request in flight; with p_latency=0 a drained response admits the next request same cycle.
module proc_mem_responder
  import mem_msgs::*;
  import proc_mem_responder_pkg::*;
#(
  parameter int unsigned p_num_words = 256,
  parameter logic [31:0] p_base_addr = 32'h0,
  parameter int unsigned p_latency   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  proc_mem_responder_if.slave  mem,
  output logic                 oob_error
);

  localparam int IDX_W = $clog2(p_num_words);
  localparam logic [32:0] WIN_BYTES = 33'(p_num_words) << 2;
  localparam bit HAS_WAIT = (p_latency > 0);
  localparam logic [3:0] LAT_LOAD = HAS_WAIT ? 4'(p_latency - 1) : 4'd0;

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  mem_resp_4B_t resp_q, resp_nxt;
  logic         req_rdy, resp_val, accept;

  mem_req_4B_t  req;
  logic [32:0]  offset;
  logic [1:0]   off;
  logic [2:0]   nbytes;
  logic [IDX_W-1:0] word_idx;
  logic         req_oob, is_write, wr_en;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data, rd_word, rd_data;

  // Request decode; a 33-bit offset makes addresses below the base wrap above the window.
  always_comb begin
    req      = mem.reqstream_msg;
    offset   = {1'b0, req.addr} - {1'b0, p_base_addr};
    off      = req.addr[1:0];
    nbytes   = len_bytes(req.len[1:0]);
    word_idx = offset[IDX_W+1:2];
    req_oob  = (offset >= WIN_BYTES)
             || (({1'b0, off} + nbytes) > 3'd4)
             || req.len[2]
             || (req.type_ > MEM_WRITE_INIT);
    is_write = (req.type_ == MEM_WRITE) || (req.type_ == MEM_WRITE_INIT);
    wr_en    = accept && !req_oob && is_write;
    wr_be    = lane_be(nbytes) << off;
    wr_data  = req.data << {off, 3'b000};
    rd_data  = (req_oob || req.type_ != MEM_READ) ? 32'h0
             : (rd_word >> {off, 3'b000}) & lane_mask(nbytes);

    resp_nxt        = '0;
    resp_nxt.type_  = req.type_;
    resp_nxt.opaque = req.opaque;
    resp_nxt.len    = req.len[1:0];
    resp_nxt.data   = rd_data;
  end

  proc_mem_responder_array #(
    .p_num_words (p_num_words)
  ) u_array (
    .clk     (clk),
    .rd_idx  (word_idx),
    .rd_data (rd_word),
    .wr_en   (wr_en),
    .wr_idx  (word_idx),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  assign accept = mem.reqstream_val && req_rdy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (mem.reqstream_val) begin
          state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
          cnt_nxt   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: begin
        resp_val = 1'b1;
        if (mem.respstream_rdy) begin
          if (HAS_WAIT) begin
            state_nxt = ST_IDLE;
          end else begin
            // Zero latency: the slot frees this cycle, so take the next request now.
            req_rdy   = 1'b1;
            state_nxt = mem.reqstream_val ? ST_RESP : ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      resp_q    <= '0;
      oob_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) resp_q <= resp_nxt;
      if (accept && req_oob) oob_error <= 1'b1;
    end
  end

  assign mem.reqstream_rdy  = req_rdy;
  assign mem.respstream_val = resp_val;
  assign mem.respstream_msg = (state == ST_RESP) ? resp_q : '0;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: directed vector table, latency/reset sequences, random stream vs byte-level model.
module tb_proc_mem_responder;
  import mem_msgs::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic oob0, oob3;

  proc_mem_responder_if if0();
  proc_mem_responder_if if3();

  proc_mem_responder #(.p_num_words(256), .p_base_addr(32'h0), .p_latency(0))
    u_lat0 (.clk(clk), .reset(reset), .mem(if0), .oob_error(oob0));
  proc_mem_responder #(.p_num_words(256), .p_base_addr(32'h0), .p_latency(3))
    u_lat3 (.clk(clk), .reset(reset), .mem(if3), .oob_error(oob3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int sink_mode = 0;

  logic [7:0]   ref_bytes [1024];
  bit           ref_oob = 1'b0;
  mem_resp_4B_t exp_q [$];
  mem_req_4B_t  stim_q [$];
  int           log_op [$];
  int           log_cyc [$];

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
    logic [7:0]  op;
    logic [31:0] exp_data;
    bit          exp_oob;
  } vec_t;

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] a, input logic [2:0] l,
                                         input logic [31:0] d);
    mem_req_4B_t r;
    r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
    return r;
  endfunction

  function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                           input logic [1:0] l, input logic [31:0] d);
    mem_resp_4B_t r;
    r.type_ = t; r.opaque = op; r.test = 2'd0; r.len = l; r.data = d;
    return r;
  endfunction

  // Reference: a flat byte memory, little-endian within each word.
  task automatic model_apply(input mem_req_4B_t r, output mem_resp_4B_t e);
    int n, a;
    bit bad;
    logic [31:0] d;
    n   = (r.len == 3'd0) ? 4 : int'(r.len);
    bad = (r.type_ > 3'd2) || (r.len > 3'd3) || (r.addr >= 32'd1024) || ((r.addr % 4) + n > 4);
    d   = 32'h0;
    if (bad) begin
      ref_oob = 1'b1;
    end else begin
      a = int'(r.addr);
      for (int i = 0; i < n; i++) begin
        if (r.type_ == MEM_READ) d[8*i +: 8] = ref_bytes[a + i];
        else                     ref_bytes[a + i] = r.data[8*i +: 8];
      end
    end
    e = mk_resp(r.type_, r.opaque, r.len[1:0], d);
  endtask

  function automatic mem_req_4B_t rand_req(input logic [7:0] op);
    int kind, word, n, off;
    logic [2:0] t;
    logic [2:0] l;
    kind = $urandom_range(0, 9);
    word = $urandom_range(0, 15);
    l    = 3'($urandom_range(0, 3));
    n    = (l == 3'd0) ? 4 : int'(l);
    off  = $urandom_range(0, 4 - n);
    t    = (kind < 5) ? MEM_READ : (kind < 7) ? MEM_WRITE : (kind == 7) ? MEM_WRITE_INIT
         : 3'($urandom_range(3, 7));
    if (kind == 9) begin
      t = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) return mk_req(t, op, 32'h400 + 32'(word * 4), 3'd0, $urandom);
      return mk_req(t, op, 32'(word * 4 + 3), 3'd0, $urandom);
    end
    return mk_req(t, op, 32'(word * 4 + off), l, $urandom);
  endfunction

  // Watches the latency-0 DUT: scoreboard order, payload, sticky flag and stall stability.
  task automatic monitor_loop();
    bit held = 1'b0;
    mem_resp_4B_t held_msg, e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        held = 1'b0;
        continue;
      end
      if (if0.respstream_val) begin
        if (held) chk("resp_stable", 78'(if0.respstream_msg), 78'(held_msg));
        if (if0.respstream_rdy) begin
          held = 1'b0;
          chk("resp_expected", 78'(exp_q.size() != 0), 78'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_msg", 78'(if0.respstream_msg), 78'(e));
            chk("resp_oob_flag", 78'(oob0), 78'(ref_oob));
            log_op.push_back(int'(if0.respstream_msg.opaque));
            log_cyc.push_back(cyc);
          end
        end else begin
          held = 1'b1;
          held_msg = if0.respstream_msg;
        end
      end else if (held) begin
        chk("resp_dropped", 78'(if0.respstream_val), 78'(1));
        held = 1'b0;
      end
      if (if0.reqstream_val && if0.reqstream_rdy) begin
        model_apply(if0.reqstream_msg, e);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic sink_loop();
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       if0.respstream_rdy = 1'b1;
        1:       if0.respstream_rdy = ~if0.respstream_rdy;
        2:       if0.respstream_rdy = 1'($urandom_range(0, 1));
        default: if0.respstream_rdy = 1'b0;
      endcase
    end
  endtask

  task automatic watchdog();
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  endtask

  task automatic wait_req_rdy0();
    int t = 0;
    @(negedge clk);
    while (!if0.reqstream_rdy && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("req_accept_timeout", 78'(if0.reqstream_rdy), 78'(1));
  endtask

  task automatic do_txn0(input mem_req_4B_t r, output mem_resp_4B_t resp);
    int t = 0;
    @(posedge clk); #1;
    if0.reqstream_val = 1'b1;
    if0.reqstream_msg = r;
    wait_req_rdy0();
    @(posedge clk); #1;
    if0.reqstream_val = 1'b0;
    @(negedge clk);
    while (!if0.respstream_val && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("resp_timeout", 78'(if0.respstream_val), 78'(1));
    resp = if0.respstream_msg;
  endtask

  task automatic drive_stream(input bit gaps);
    @(posedge clk); #1;
    while (stim_q.size() > 0) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        if0.reqstream_val = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      if0.reqstream_val = 1'b1;
      if0.reqstream_msg = stim_q[0];
      wait_req_rdy0();
      @(posedge clk); #1;
      void'(stim_q.pop_front());
    end
    if0.reqstream_val = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || if0.respstream_val) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 78'(exp_q.size()), 78'(0));
  endtask

  // Latency-3 transaction with cycle-exact timing checks from accept to response.
  task automatic txn3_timed(input string name, input mem_req_4B_t r, input mem_resp_4B_t e);
    int t = 0;
    @(posedge clk); #1;
    if3.reqstream_val = 1'b1;
    if3.reqstream_msg = r;
    @(negedge clk);
    while (!if3.reqstream_rdy && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk({name, "_accept_timeout"}, 78'(if3.reqstream_rdy), 78'(1));
    @(posedge clk); #1;
    if3.reqstream_val = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_rdy_c%0d", name, k), 78'(if3.reqstream_rdy), 78'(0));
      chk($sformatf("%s_val_c%0d", name, k), 78'(if3.respstream_val), 78'(k == 4));
    end
    chk({name, "_msg"}, 78'(if3.respstream_msg), 78'(e));
    @(negedge clk);
    chk({name, "_idle_val"}, 78'(if3.respstream_val), 78'(0));
    chk({name, "_idle_rdy"}, 78'(if3.reqstream_rdy), 78'(1));
  endtask

  initial begin
    vec_t vecs [$];
    mem_resp_4B_t resp;
    int t;

    if0.reqstream_val = 1'b0; if0.reqstream_msg = '0; if0.respstream_rdy = 1'b1;
    if3.reqstream_val = 1'b0; if3.reqstream_msg = '0; if3.respstream_rdy = 1'b1;
    fork
      monitor_loop();
      sink_loop();
      watchdog();
    join_none

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_rdy0", 78'(if0.reqstream_rdy), 78'(1));
    chk("rst_val0", 78'(if0.respstream_val), 78'(0));
    chk("rst_msg0", 78'(if0.respstream_msg), 78'(0));
    chk("rst_oob0", 78'(oob0), 78'(0));
    chk("rst_rdy3", 78'(if3.reqstream_rdy), 78'(1));
    chk("rst_val3", 78'(if3.respstream_val), 78'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors: byte lanes, partial writes, out-of-bounds and unknown types.
    vecs.push_back('{MEM_WRITE_INIT, 32'h008, 3'd0, 32'hDEADBEEF, 8'd1,  32'h0,        1'b0});
    vecs.push_back('{MEM_READ,       32'h008, 3'd0, 32'h0,       8'd5,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{MEM_WRITE,      32'h009, 3'd1, 32'h123456AA, 8'd2, 32'h0,        1'b0});
    vecs.push_back('{MEM_READ,       32'h008, 3'd0, 32'h0,       8'd3,  32'hDEADAAEF, 1'b0});
    vecs.push_back('{MEM_READ,       32'h009, 3'd1, 32'h0,       8'd4,  32'h000000AA, 1'b0});
    vecs.push_back('{MEM_READ,       32'h00A, 3'd2, 32'h0,       8'd6,  32'h0000DEAD, 1'b0});
    vecs.push_back('{MEM_READ,       32'h00B, 3'd1, 32'h0,       8'd7,  32'h000000DE, 1'b0});
    vecs.push_back('{MEM_WRITE,      32'h00E, 3'd2, 32'hFFFF1234, 8'd8, 32'h0,        1'b0});
    vecs.push_back('{MEM_READ,       32'h00E, 3'd2, 32'h0,       8'd9,  32'h00001234, 1'b0});
    vecs.push_back('{MEM_READ,       32'h00F, 3'd1, 32'h0,       8'd10, 32'h00000012, 1'b0});
    vecs.push_back('{MEM_WRITE,      32'h008, 3'd3, 32'h00C0FFEE, 8'd11, 32'h0,       1'b0});
    vecs.push_back('{MEM_READ,       32'h008, 3'd0, 32'h0,       8'd12, 32'hDEC0FFEE, 1'b0});
    vecs.push_back('{MEM_READ,       32'h00A, 3'd0, 32'h0,       8'd13, 32'h0,        1'b1});
    vecs.push_back('{MEM_READ,       32'h400, 3'd0, 32'h0,       8'd14, 32'h0,        1'b1});
    vecs.push_back('{3'd3,           32'h008, 3'd0, 32'h0,       8'd15, 32'h0,        1'b1});
    vecs.push_back('{MEM_WRITE,      32'h408, 3'd0, 32'h11111111, 8'd16, 32'h0,       1'b1});
    vecs.push_back('{MEM_READ,       32'h008, 3'd0, 32'h0,       8'd17, 32'hDEC0FFEE, 1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      do_txn0(mk_req(vecs[i].typ, vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data), resp);
      chk($sformatf("vec%0d_resp", i), 78'(resp),
          78'(mk_resp(vecs[i].typ, vecs[i].op, vecs[i].len[1:0], vecs[i].exp_data)));
      chk($sformatf("vec%0d_oob", i), 78'(oob0), 78'(vecs[i].exp_oob));
    end

    // Latency 3: timing of write-init and reads.
    txn3_timed("lat3_wi", mk_req(MEM_WRITE_INIT, 8'h21, 32'h10, 3'd0, 32'hCAFEF00D),
               mk_resp(MEM_WRITE_INIT, 8'h21, 2'd0, 32'h0));
    txn3_timed("lat3_rd", mk_req(MEM_READ, 8'h22, 32'h10, 3'd0, 32'h0),
               mk_resp(MEM_READ, 8'h22, 2'd0, 32'hCAFEF00D));
    txn3_timed("lat3_rd_hi", mk_req(MEM_READ, 8'h23, 32'h12, 3'd2, 32'h0),
               mk_resp(MEM_READ, 8'h23, 2'd2, 32'h0000CAFE));
    chk("lat3_oob", 78'(oob3), 78'(0));

    // Initialise the random-test region (words 0..15).
    for (int w = 0; w < 16; w++)
      stim_q.push_back(mk_req(MEM_WRITE_INIT, 8'(w), 32'(w * 4), 3'd0, $urandom));
    sink_mode = 0;
    drive_stream(1'b0);
    drain();

    // 8 back-to-back reads, sink always ready.
    log_op.delete(); log_cyc.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(mk_req(MEM_READ, 8'(i), 32'(i * 4), 3'd0, 32'h0));
    drive_stream(1'b0);
    drain();
    chk("b2b_count", 78'(log_op.size()), 78'(8));
    for (int i = 0; i < log_op.size() && i < 8; i++) begin
      chk($sformatf("b2b_op%0d", i), 78'(log_op[i]), 78'(i));
      chk($sformatf("b2b_cyc%0d", i), 78'(log_cyc[i] - log_cyc[0]), 78'(i));
    end

    // Same stream with a toggling sink.
    log_op.delete(); log_cyc.delete();
    sink_mode = 1;
    for (int i = 0; i < 8; i++) stim_q.push_back(mk_req(MEM_READ, 8'(i), 32'(i * 4), 3'd0, 32'h0));
    drive_stream(1'b0);
    drain();
    chk("tog_count", 78'(log_op.size()), 78'(8));
    for (int i = 0; i < log_op.size() && i < 8; i++)
      chk($sformatf("tog_op%0d", i), 78'(log_op[i]), 78'(i));

    // Random traffic against the byte model.
    sink_mode = 2;
    for (int i = 0; i < 300; i++) stim_q.push_back(rand_req(8'(i)));
    drive_stream(1'b1);
    drain();

    // Out-of-bounds read stalled in RESP, then reset mid-response.
    sink_mode = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    ref_oob = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("r6_oob_clear", 78'(oob0), 78'(0));
    sink_mode = 3;
    @(posedge clk); #1;
    if0.reqstream_val = 1'b1;
    if0.reqstream_msg = mk_req(MEM_READ, 8'h66, 32'h400, 3'd0, 32'h0);
    wait_req_rdy0();
    @(posedge clk); #1;
    if0.reqstream_val = 1'b0;
    t = 0;
    @(negedge clk);
    while (!if0.respstream_val && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("r6_val", 78'(if0.respstream_val), 78'(1));
    chk("r6_msg", 78'(if0.respstream_msg), 78'(mk_resp(MEM_READ, 8'h66, 2'd0, 32'h0)));
    chk("r6_oob_set", 78'(oob0), 78'(1));
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("r6_rst_val", 78'(if0.respstream_val), 78'(0));
    chk("r6_rst_rdy", 78'(if0.reqstream_rdy), 78'(1));
    chk("r6_rst_msg", 78'(if0.respstream_msg), 78'(0));
    chk("r6_rst_oob", 78'(oob0), 78'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    ref_oob = 1'b0;
    exp_q.delete();
    sink_mode = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("r6_post_val%0d", k), 78'(if0.respstream_val), 78'(0));
    end
    chk("r6_post_rdy", 78'(if0.reqstream_rdy), 78'(1));
    chk("r6_post_oob", 78'(oob0), 78'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
